// File: rtl/mul_div_unit.sv
// Iterative radix-2 RV32M multiply/divide unit between register-file read and write ports.
// Every operation takes DATA_WIDTH+1 cycles from the accepting edge to the done pulse.
module mul_div_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    input  logic [ADDRESS_WIDTH-1:0] rd_in,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [ADDRESS_WIDTH-1:0] rd_out
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         count;
    logic [2:0]               op_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic                     neg_q;
    logic [W:0]               acc_hi;
    logic [W-1:0]             acc_lo;
    logic [W-1:0]             opnd;

    logic                     accept, last_iter;
    logic                     a_signed, b_signed, a_neg, b_neg, res_neg_in;
    logic signed [W-1:0]      a_sv, b_sv;
    logic [W-1:0]             mag_a, mag_b;
    logic [W:0]               mul_sum, div_shift;
    logic [W+1:0]             div_diff;
    logic [W:0]               hi_nxt;
    logic [W-1:0]             lo_nxt;
    logic [2*W-1:0]           prod_fix;
    logic [W-1:0]             quot_fix, rem_fix, fin_val;

    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign accept    = start && ((state == IDLE) || (state == FIN));
    assign last_iter = (state == CALC) && (count == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (last_iter) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = start ? CALC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand decode: signedness per funct3, magnitudes and the sign the result must carry.
    assign a_sv     = op_a;
    assign b_sv     = op_b;
    assign a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg    = a_signed && (a_sv < 0);
    assign b_neg    = b_signed && (b_sv < 0);
    assign mag_a    = cond_neg(op_a, a_neg);
    assign mag_b    = cond_neg(op_b, b_neg);

    // A zero divisor keeps the quotient all ones, so the sign flip is suppressed for it.
    always_comb begin
        res_neg_in = a_neg ^ b_neg;
        if (funct3[2]) begin
            if (funct3[1]) res_neg_in = a_neg;
            else           res_neg_in = (op_b != '0) && (a_neg ^ b_neg);
        end
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    assign mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi[W-1:0], acc_lo[W-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};

    always_comb begin
        if (op_q[2]) begin
            if (!div_diff[W+1]) begin
                hi_nxt = div_diff[W:0];
                lo_nxt = {acc_lo[W-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift;
                lo_nxt = {acc_lo[W-2:0], 1'b0};
            end
        end else begin
            hi_nxt = {1'b0, mul_sum[W:1]};
            lo_nxt = {mul_sum[0], acc_lo[W-1:1]};
        end
    end

    assign prod_fix = cond_neg2({hi_nxt[W-1:0], lo_nxt}, neg_q);
    assign quot_fix = cond_neg(lo_nxt, neg_q);
    assign rem_fix  = cond_neg(hi_nxt[W-1:0], neg_q);

    always_comb begin
        case (op_q)
            3'b000:                fin_val = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: fin_val = prod_fix[2*W-1:W];
            3'b100, 3'b101:        fin_val = quot_fix;
            default:               fin_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count  <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            neg_q  <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            if (accept) begin
                op_q   <= funct3;
                rd_q   <= rd_in;
                neg_q  <= res_neg_in;
                acc_hi <= '0;
                acc_lo <= mag_a;
                opnd   <= mag_b;
                count  <= CNT_W'(DATA_WIDTH);
            end else if (state == CALC) begin
                acc_hi <= hi_nxt;
                acc_lo <= lo_nxt;
                if (count != '0) count <= count - CNT_W'(1);
            end
            if (last_iter) begin
                result <= fin_val;
                rd_out <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed corner cases plus random ops against a 64-bit arithmetic model.
module tb_mul_div_unit;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    funct3;
    logic [W-1:0]  op_a, op_b;
    logic [AW-1:0] rd_in;
    logic          busy, done;
    logic [W-1:0]  result;
    logic [AW-1:0] rd_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.DATA_WIDTH(W), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, sbu, p;
        logic [63:0]        ua, ub, pu;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        sbu = {32'h0, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * sbu; return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one op in the current cycle and returns in its done cycle (or at the bound).
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output bit busy_bad);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        tick;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom);
        lat = 1;
        busy_bad = 1'b0;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            tick;
            lat++;
        end
        if (busy !== 1'b0) busy_bad = 1'b1;
    endtask

    task automatic run_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        bit bb;
        do_op(f, a, b, rd, lat, bb);
        check({tag, " latency"}, lat, 33);
        check({tag, " busy"}, 32'(bb), 32'd0);
        check({tag, " result"}, result, exp);
        check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    endtask

    initial begin
        int cyc;
        bit seen;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;

        rst = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) tick;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", 32'(rd_out), 32'd0);
        rst = 1'b1;
        tick;

        run_check("mul 7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        tick;
        check("done one-shot", 32'(done), 32'd0);
        check("result hold", result, 32'hFFFF_FFEB);

        run_check("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
        run_check("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000);
        run_check("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
        run_check("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
        run_check("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
        run_check("divu 100/7", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14);
        run_check("remu 100/7", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2);
        run_check("divu 5/0", 3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
        run_check("remu 5/0", 3'd7, 32'd5, 32'd0, 5'd10, 32'd5);
        run_check("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
        run_check("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0);
        run_check("div -9/0", 3'd4, 32'hFFFF_FFF7, 32'd0, 5'd13, 32'hFFFF_FFFF);
        run_check("rem -9/0", 3'd6, 32'hFFFF_FFF7, 32'd0, 5'd14, 32'hFFFF_FFF7);
        tick;

        // Second start at cycle 10 must be ignored; a start in the done cycle must be taken.
        funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3; start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            if (cyc == 10) begin
                funct3 = 3'd0; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd4; start = 1'b1;
            end
            tick;
            start = 1'b0;
            cyc++;
        end
        check("ignore start latency", 32'(cyc), 32'd33);
        check("ignore start result", result, 32'd14);
        check("ignore start rd", 32'(rd_out), 32'd3);
        funct3 = 3'd7; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd6; start = 1'b1;
        tick;
        start = 1'b0;
        cyc++;
        while (!done && cyc < 200) begin
            tick;
            cyc++;
        end
        check("back-to-back cycle", 32'(cyc), 32'd66);
        check("back-to-back result", result, 32'd2);
        check("back-to-back rd", 32'(rd_out), 32'd6);
        tick;
        check("no extra done", 32'(done), 32'd0);

        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'h8000_0000;
                3: b = $urandom_range(0, 20);
                default: b = $urandom;
            endcase
            rd = 5'($urandom);
            run_check($sformatf("rand%0d f%0d a=%h b=%h", i, f, a, b), f, a, b, rd,
                      ref_model(f, a, b));
            if ($urandom_range(0, 1) == 1) begin
                tick;
                check($sformatf("rand%0d idle done", i), 32'(done), 32'd0);
            end
        end
        tick;

        // Reset in the middle of a divide aborts it without a done pulse.
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd9; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i < 12; i++) tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        check("abort rd_out", 32'(rd_out), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick;
            if (done || busy) seen = 1'b1;
        end
        check("abort no done", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
